// File: rtl/router_port_deser_if.sv
// Serial router-output side plus the valid/ready byte stream toward the consumer.
interface router_port_deser_if;
  logic       din;
  logic       frame_n;
  logic       valid_n;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_valid;
  logic       m_ready;

  modport master (
    output din, frame_n, valid_n, m_ready,
    input  m_data, m_last, m_valid
  );

  modport slave (
    input  din, frame_n, valid_n, m_ready,
    output m_data, m_last, m_valid
  );
endinterface

// File: rtl/router_port_deser.sv
// Router output-port receiver: rebuilds LSB-first bytes from one serial channel,
// tags packet-final bytes and buffers them in a small FIFO for the consumer.
module router_port_deser #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  router_port_deser_if.slave   bus,
  output logic [CNT_W-1:0]     pkt_cnt,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic                 err_len,
  output logic                 err_abort,
  input  logic                 clr_err
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned EW = 9;

  typedef enum logic [0:0] {IDLE, RECV} state_t;

  state_t         state_q, state_d;
  logic [2:0]     bitcnt_q;
  logic [7:0]     shreg_q;

  logic           accept_c;
  logic           last_c;
  logic           abort_c;
  logic           push_c;
  logic [7:0]     byte_c;
  logic           err_len_set_c;

  logic [EW-1:0]  mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr_q, rd_ptr_q;
  logic           full_c, empty_c, push_ok_c, pop_c;
  logic [EW-1:0]  head_c;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: a frame start moves to RECV; any frame_n high while receiving ends it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!bus.frame_n) state_d = RECV;
      RECV:    if (bus.frame_n)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-cycle decode of the serial stream
  always_comb begin
    accept_c      = 1'b0;
    last_c        = 1'b0;
    abort_c       = 1'b0;
    push_c        = 1'b0;
    err_len_set_c = 1'b0;
    byte_c        = shreg_q;
    byte_c[bitcnt_q] = bus.din;
    case (state_q)
      IDLE: accept_c = !bus.frame_n && !bus.valid_n;
      RECV: begin
        accept_c = !bus.valid_n;
        last_c   = !bus.valid_n && bus.frame_n;
        abort_c  = bus.valid_n && bus.frame_n;
      end
      default: ;
    endcase
    push_c        = accept_c && (last_c || (bitcnt_q == 3'd7));
    err_len_set_c = last_c && (bitcnt_q != 3'd7);
  end

  // Byte assembly; shreg is cleared after each push so partial bytes are zero-filled
  always_ff @(posedge clk) begin
    if (reset || abort_c) begin
      bitcnt_q <= 3'd0;
      shreg_q  <= 8'd0;
    end else if (accept_c) begin
      bitcnt_q <= last_c ? 3'd0 : 3'(bitcnt_q + 3'd1);
      shreg_q  <= push_c ? 8'd0 : byte_c;
    end
  end

  // FIFO with one extra pointer bit to tell full from empty
  assign empty_c   = (wr_ptr_q == rd_ptr_q);
  assign full_c    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign push_ok_c = push_c && !full_c;
  assign pop_c     = !empty_c && bus.m_ready;
  assign head_c    = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr_q[AW-1:0]] <= {last_c, byte_c};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok_c) wr_ptr_q <= (AW+1)'(wr_ptr_q + 1'b1);
      if (pop_c)     rd_ptr_q <= (AW+1)'(rd_ptr_q + 1'b1);
    end
  end

  assign bus.m_valid = !empty_c;
  assign bus.m_data  = empty_c ? 8'd0 : head_c[7:0];
  assign bus.m_last  = empty_c ? 1'b0 : head_c[8];

  // Status: saturating counters and sticky errors; clr_err beats same-cycle updates
  always_ff @(posedge clk) begin
    if (reset || clr_err) begin
      pkt_cnt   <= '0;
      drop_cnt  <= '0;
      err_len   <= 1'b0;
      err_abort <= 1'b0;
    end else begin
      if (push_ok_c && last_c && (pkt_cnt != '1))
        pkt_cnt <= CNT_W'(pkt_cnt + 1'b1);
      if (push_c && full_c && (drop_cnt != '1))
        drop_cnt <= CNT_W'(drop_cnt + 1'b1);
      if (err_len_set_c) err_len   <= 1'b1;
      if (abort_c)       err_abort <= 1'b1;
    end
  end

endmodule

// File: tb/tb_router_port_deser.sv
// Scoreboard bench for router_port_deser: bytes queued as bits are driven, checked on pop.
module tb_router_port_deser;

  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned CNT_W      = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             clr_err;
  logic [CNT_W-1:0] pkt_cnt, drop_cnt;
  logic             err_len, err_abort;

  router_port_deser_if intf();

  router_port_deser #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (intf),
    .pkt_cnt   (pkt_cnt),
    .drop_cnt  (drop_cnt),
    .err_len   (err_len),
    .err_abort (err_abort),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [8:0] exp_q[$];
  logic [7:0] pkt[$];
  logic [8:0] mon_exp;
  int         exp_pkt, exp_drop;
  logic       exp_err_len, exp_err_abort;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    intf.frame_n = 1'b1;
    intf.valid_n = 1'b1;
    intf.din     = 1'b0;
  endtask

  // Model of the FIFO push decision: occupancy seen here is the DUT occupancy before the edge
  task automatic model_byte(input logic [7:0] b, input bit last);
    if (exp_q.size() >= FIFO_DEPTH) begin
      if (exp_drop < 255) exp_drop++;
    end else begin
      exp_q.push_back({last, b});
      if (last && exp_pkt < 255) exp_pkt++;
    end
  endtask

  task automatic send_pkt(input int nbits, input bit stalls, input bit lat_chk,
                          input bit clr_last, input bit open);
    for (int i = 0; i < nbits; i++) begin
      logic [7:0] cur;
      logic [7:0] b;
      bit         last;
      bit         done;
      int         pos;
      if (stalls && (i % 2 == 1)) begin
        intf.frame_n = 1'b0;
        intf.valid_n = 1'b1;
        tick();
      end
      pos  = i % 8;
      cur  = pkt[i / 8];
      last = (i == nbits - 1) && !open;
      done = (pos == 7) || last;
      b    = 8'd0;
      for (int k = 0; k < 8; k++) if (k <= pos) b[k] = cur[k];
      intf.din     = cur[pos];
      intf.frame_n = last;
      intf.valid_n = 1'b0;
      if (last && clr_last) clr_err = 1'b1;
      if (done) begin
        model_byte(b, last);
        if (last && pos != 7) exp_err_len = 1'b1;
      end
      tick();
      clr_err = 1'b0;
      if (lat_chk && done) begin
        check_eq("lat_valid", 32'(intf.m_valid), 32'd1);
        check_eq("lat_data",  32'(intf.m_data),  32'(b));
        check_eq("lat_last",  32'(intf.m_last),  32'(last));
      end
    end
    if (open) begin
      intf.frame_n = 1'b0;
      intf.valid_n = 1'b1;
    end else begin
      drive_idle();
    end
  endtask

  task automatic drain;
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) tick();
    check_eq("drain_left", 32'(exp_q.size()), 32'd0);
    tick();
    check_eq("drain_empty", 32'(intf.m_valid), 32'd0);
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_pkt"},   32'(pkt_cnt),   32'(exp_pkt));
    check_eq({tag, "_drop"},  32'(drop_cnt),  32'(exp_drop));
    check_eq({tag, "_elen"},  32'(err_len),   32'(exp_err_len));
    check_eq({tag, "_eabrt"}, 32'(err_abort), 32'(exp_err_abort));
  endtask

  task automatic clear_model;
    exp_pkt       = 0;
    exp_drop      = 0;
    exp_err_len   = 1'b0;
    exp_err_abort = 1'b0;
  endtask

  // Consumer-side monitor: a handshake seen here completes on the next rising edge
  always @(negedge clk) begin
    if (!reset && intf.m_valid && intf.m_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pop", 32'(intf.m_valid), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("pop_data", 32'(intf.m_data), 32'(mon_exp[7:0]));
        check_eq("pop_last", 32'(intf.m_last), 32'(mon_exp[8]));
      end
    end
  end

  initial begin
    reset        = 1'b1;
    clr_err      = 1'b0;
    intf.m_ready = 1'b0;
    drive_idle();
    clear_model();
    repeat (2) tick();

    check_eq("rst_valid", 32'(intf.m_valid), 32'd0);
    check_eq("rst_data",  32'(intf.m_data),  32'd0);
    check_eq("rst_last",  32'(intf.m_last),  32'd0);
    check_status("rst");
    reset = 1'b0;
    tick();

    // Two-byte packet, byte visible one cycle after its final bit
    intf.m_ready = 1'b1;
    pkt = '{8'hA5, 8'h3C};
    send_pkt(16, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();
    check_status("basic");

    // Same packet with a stall before every odd bit
    send_pkt(16, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    check_status("stall");

    // 11-bit packet: second byte is zero-filled, length error set
    pkt = '{8'hFF, 8'hFF};
    send_pkt(11, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    check_status("len");

    // Abort after 5 bits, then a clean packet
    pkt = '{8'h1B};
    for (int i = 0; i < 5; i++) begin
      logic [7:0] cur;
      cur          = pkt[0];
      intf.din     = cur[i];
      intf.frame_n = 1'b0;
      intf.valid_n = 1'b0;
      tick();
    end
    intf.frame_n  = 1'b1;
    intf.valid_n  = 1'b1;
    exp_err_abort = 1'b1;
    tick();
    tick();
    check_eq("abort_nopush", 32'(intf.m_valid), 32'd0);
    pkt = '{8'h5A, 8'hC3};
    send_pkt(16, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    check_status("abort");

    // Random packets of assorted lengths
    for (int p = 0; p < 4; p++) begin
      pkt.delete();
      for (int k = 0; k < 5; k++) pkt.push_back(8'($urandom_range(0, 255)));
      send_pkt(int'($urandom_range(9, 40)), 1'(p % 2), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drain();
    check_status("rand");

    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    clear_model();
    check_status("clr");

    // FIFO full: 10-byte packet with the consumer stalled
    intf.m_ready = 1'b0;
    pkt.delete();
    for (int k = 0; k < 10; k++) pkt.push_back(8'(k * 17 + 1));
    send_pkt(80, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("full_valid", 32'(intf.m_valid), 32'd1);
    check_status("full");
    intf.m_ready = 1'b1;
    drain();

    // Reset mid-packet with 3 bytes buffered
    intf.m_ready = 1'b0;
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(28, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    exp_q.delete();
    clear_model();
    tick();
    check_eq("midrst_valid", 32'(intf.m_valid), 32'd0);
    check_status("midrst");
    reset = 1'b0;
    drive_idle();
    tick();

    // Clear coinciding with a drop: cleared value wins
    pkt.delete();
    for (int k = 0; k < 9; k++) pkt.push_back(8'(8'hF0 ^ k));
    send_pkt(72, 1'b0, 1'b0, 1'b1, 1'b0);
    clear_model();
    tick();
    check_status("clrdrop");
    intf.m_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
